// File: rtl/mac_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter_pkg
// Shared definitions for the MAC TX arbitration slice: the Avalon-ST beat
// geometry of the MAC TX port, the arbiter state encoding, and a small
// modular-add helper used by the round-robin picker and pointer update.
// No ports (package).
// ---------------------------------------------------------------------------
package mac_tx_arbiter_pkg;

  localparam int MAC_DATA_W  = 64;
  localparam int MAC_EMPTY_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arbState_t;

  // (a + b) mod n for 0 <= a,b < n; avoids a real divider for non-power-of-2 n
  function automatic int wrapAdd(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first asserted request found
// when searching i_ptr, i_ptr+1, ... (mod NUM_REQ). Shared with the RX-side
// demux/scheduler blocks.
// Ports:
//   i_req    NUM_REQ  request vector
//   i_ptr    IDX_W    highest-priority index for this search
//   o_found  1        at least one request is asserted
//   o_index  IDX_W    index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_index
);

  import mac_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0] w_rot;

  // Rotate the request vector so that bit 0 is the requester at i_ptr;
  // duplicating the vector makes the rotate a plain right shift.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  // Scan from the far end towards offset 0 so the closest request to the
  // pointer is the last one written and therefore wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        o_index = IDX_W'(wrapAdd(int'(i_ptr), i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter
// Packet-granular round-robin arbiter sharing one Avalon-ST MAC TX port among
// NUM_REQ packet sources. A grant is locked from SOP to the accepted EOP beat
// so packets never interleave. One registered output stage; sticky protocol
// error flags.
// Ports:
//   clockMac, resetMac          clock, synchronous active-high reset
//   req_valid/ready/sop/eop/error  per-requester Avalon-ST handshake and flags
//   req_data, req_empty         flattened per-requester beat payload
//   tx_valid/ready/sop/eop/error/data/empty  registered MAC TX stream
//   grant_id                    current or last granted requester
//   busy                        a packet grant is active
//   pkt_done                    pulse on acceptance of the granted EOP beat
//   err_clear                   clears sticky error flags (a new error wins)
//   err_orphan                  non-SOP beat seen while idle (beat dropped)
//   err_sop                     SOP seen inside a granted packet
// ---------------------------------------------------------------------------
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  DATA_W  = MAC_DATA_W,
  parameter int  EMPTY_W = MAC_EMPTY_W,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clockMac,
  input  logic                       resetMac,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_sop,
  input  logic [NUM_REQ-1:0]         req_eop,
  input  logic [NUM_REQ-1:0]         req_error,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*EMPTY_W-1:0] req_empty,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_sop,
  output logic                       tx_eop,
  output logic                       tx_error,
  output logic [DATA_W-1:0]          tx_data,
  output logic [EMPTY_W-1:0]         tx_empty,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       pkt_done,
  input  logic                       err_clear,
  output logic                       err_orphan,
  output logic                       err_sop
);

  arbState_t          r_state;
  arbState_t          w_stateNext;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [IDX_W-1:0]   r_grantId;
  logic               r_firstBeat;

  logic               r_txValid;
  logic               r_txSop;
  logic               r_txEop;
  logic               r_txError;
  logic [DATA_W-1:0]  r_txData;
  logic [EMPTY_W-1:0] r_txEmpty;
  logic               r_errOrphan;
  logic               r_errSop;

  logic [NUM_REQ-1:0] w_sopReq;
  logic [NUM_REQ-1:0] w_orphanReq;
  logic               w_pickFound;
  logic [IDX_W-1:0]   w_pickIdx;
  logic               w_outFree;
  logic               w_gValid;
  logic               w_gSop;
  logic               w_gEop;
  logic               w_gError;
  logic [DATA_W-1:0]  w_gData;
  logic [EMPTY_W-1:0] w_gEmpty;
  logic [NUM_REQ-1:0] w_reqReady;
  logic               w_accept;
  logic               w_orphan;
  logic               w_midSop;
  logic               w_pktDone;

  // Only requesters opening a packet compete; a mid-packet beat seen while
  // idle has no owner and is drained as an orphan.
  assign w_sopReq    = req_valid & req_sop;
  assign w_orphanReq = req_valid & ~req_sop;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rrPick (
    .i_req   (w_sopReq),
    .i_ptr   (r_rrPtr),
    .o_found (w_pickFound),
    .o_index (w_pickIdx)
  );

  // Output register may take a new beat when empty or being drained.
  assign w_outFree = !r_txValid || tx_ready;

  // Grant mux: view of the currently granted requester's lane.
  assign w_gValid = req_valid[r_grantId];
  assign w_gSop   = req_sop[r_grantId];
  assign w_gEop   = req_eop[r_grantId];
  assign w_gError = req_error[r_grantId];
  assign w_gData  = req_data[int'(r_grantId)*DATA_W +: DATA_W];
  assign w_gEmpty = req_empty[int'(r_grantId)*EMPTY_W +: EMPTY_W];

  // Next-state and handshake decode. Idle cycles only arbitrate (and drain
  // orphans), which costs one bubble per packet but keeps the mux off the
  // arbitration path. Everything is held off while reset is asserted so
  // req_ready and pkt_done show their reset values during the reset cycle.
  always_comb begin
    w_stateNext = r_state;
    w_reqReady  = '0;
    w_accept    = 1'b0;
    w_orphan    = 1'b0;
    w_midSop    = 1'b0;
    w_pktDone   = 1'b0;
    if (!resetMac) begin
      case (r_state)
        ST_IDLE: begin
          w_reqReady = w_orphanReq;
          w_orphan   = |w_orphanReq;
          if (w_pickFound) w_stateNext = ST_BUSY;
        end
        ST_BUSY: begin
          w_reqReady[r_grantId] = w_outFree;
          w_accept = w_outFree && w_gValid;
          if (w_accept) begin
            w_midSop = w_gSop && !r_firstBeat;
            if (w_gEop) begin
              w_pktDone   = 1'b1;
              w_stateNext = ST_IDLE;
            end
          end
        end
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Arbitration state: grant is latched at the pick and only released by an
  // accepted EOP; the pointer then moves just past the finished requester.
  // Error flags are sticky, and a new error in the clear cycle keeps the flag.
  always_ff @(posedge clockMac) begin
    if (resetMac) begin
      r_state     <= ST_IDLE;
      r_rrPtr     <= '0;
      r_grantId   <= '0;
      r_firstBeat <= 1'b1;
      r_errOrphan <= 1'b0;
      r_errSop    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == ST_IDLE && w_pickFound) begin
        r_grantId   <= w_pickIdx;
        r_firstBeat <= 1'b1;
      end
      if (w_accept) begin
        r_firstBeat <= 1'b0;
        if (w_gEop) r_rrPtr <= IDX_W'(wrapAdd(int'(r_grantId), 1, NUM_REQ));
      end
      r_errOrphan <= (r_errOrphan && !err_clear) || w_orphan;
      r_errSop    <= (r_errSop && !err_clear) || w_midSop;
    end
  end

  // Output stage: holds while the MAC stalls. A stray SOP inside a packet is
  // still forwarded but flagged as an errored beat, and the empty field is
  // only meaningful on EOP so it is zeroed elsewhere.
  always_ff @(posedge clockMac) begin
    if (resetMac) begin
      r_txValid <= 1'b0;
      r_txSop   <= 1'b0;
      r_txEop   <= 1'b0;
      r_txError <= 1'b0;
      r_txData  <= '0;
      r_txEmpty <= '0;
    end else if (w_outFree) begin
      if (w_accept) begin
        r_txValid <= 1'b1;
        r_txSop   <= w_gSop;
        r_txEop   <= w_gEop;
        r_txError <= w_gError || w_midSop;
        r_txData  <= w_gData;
        r_txEmpty <= w_gEop ? w_gEmpty : '0;
      end else begin
        r_txValid <= 1'b0;
      end
    end
  end

  assign req_ready  = w_reqReady;
  assign tx_valid   = r_txValid;
  assign tx_sop     = r_txSop;
  assign tx_eop     = r_txEop;
  assign tx_error   = r_txError;
  assign tx_data    = r_txData;
  assign tx_empty   = r_txEmpty;
  assign grant_id   = r_grantId;
  assign busy       = (r_state == ST_BUSY);
  assign pkt_done   = w_pktDone;
  assign err_orphan = r_errOrphan;
  assign err_sop    = r_errSop;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_arbiter
// Directed bench for mac_tx_arbiter with two requesters. Inputs change 2 time
// units after a rising edge and outputs are sampled 1 unit later, well clear
// of the active edge.
// ---------------------------------------------------------------------------
module tb_mac_tx_arbiter;

  logic         clockMac = 1'b0;
  logic         resetMac;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_sop;
  logic [1:0]   req_eop;
  logic [1:0]   req_error;
  logic [127:0] req_data;
  logic [5:0]   req_empty;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_sop;
  logic         tx_eop;
  logic         tx_error;
  logic [63:0]  tx_data;
  logic [2:0]   tx_empty;
  logic [0:0]   grant_id;
  logic         busy;
  logic         pkt_done;
  logic         err_clear;
  logic         err_orphan;
  logic         err_sop;

  int assertCount = 0;
  int failCount   = 0;

  mac_tx_arbiter #(.NUM_REQ(2), .DATA_W(64), .EMPTY_W(3)) dut (
    .clockMac   (clockMac),
    .resetMac   (resetMac),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sop    (req_sop),
    .req_eop    (req_eop),
    .req_error  (req_error),
    .req_data   (req_data),
    .req_empty  (req_empty),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .tx_error   (tx_error),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .grant_id   (grant_id),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .err_clear  (err_clear),
    .err_orphan (err_orphan),
    .err_sop    (err_sop)
  );

  // 10-unit clock period.
  initial forever #5 clockMac = ~clockMac;

  // Hard time limit so a wedged run still terminates with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [63:0] beatData(input int r, input int p, input int b);
    return {16'hDA7A, 16'(r), 16'(p), 16'(b)};
  endfunction

  task automatic tick();
    @(posedge clockMac);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input bit v, input bit s, input bit e,
                               input bit er, input logic [63:0] d, input logic [2:0] emp);
    req_valid[r]          = v;
    req_sop[r]            = s;
    req_eop[r]            = e;
    req_error[r]          = er;
    req_data[r*64 +: 64]  = d;
    req_empty[r*3 +: 3]   = emp;
  endtask

  // One packet from requester r with tx_ready held high: one arbitration
  // bubble, then one beat per cycle, each visible on tx the following cycle.
  // sopBeat >= 1 places a stray SOP on that beat.
  task automatic sendPacket(input int r, input int n, input int pk, input int sopBeat);
    logic [1:0] expReady;
    bit s;
    bit e;
    expReady = 2'b01 << r;
    applyStimulus(r, 1'b1, 1'b1, n == 1, 1'b0, beatData(r, pk, 0), (n == 1) ? 3'd5 : 3'd7);
    #1;
    checkOutput($sformatf("p%0d_bubble_ready", pk), 64'(req_ready[r]), 64'd0);
    tick();
    checkOutput($sformatf("p%0d_grant", pk), 64'(grant_id), 64'(r));
    checkOutput($sformatf("p%0d_busy", pk), 64'(busy), 64'd1);
    for (int b = 0; b < n; b++) begin
      s = (b == 0) || (b == sopBeat);
      e = (b == n - 1);
      applyStimulus(r, 1'b1, s, e, 1'b0, beatData(r, pk, b), e ? 3'd5 : 3'd7);
      #1;
      checkOutput($sformatf("p%0d_b%0d_ready", pk, b), 64'(req_ready), 64'(expReady));
      checkOutput($sformatf("p%0d_b%0d_pkt_done", pk, b), 64'(pkt_done), 64'(e));
      tick();
      checkOutput($sformatf("p%0d_b%0d_tx_valid", pk, b), 64'(tx_valid), 64'd1);
      checkOutput($sformatf("p%0d_b%0d_tx_data", pk, b), tx_data, beatData(r, pk, b));
      checkOutput($sformatf("p%0d_b%0d_tx_sop", pk, b), 64'(tx_sop), 64'(s));
      checkOutput($sformatf("p%0d_b%0d_tx_eop", pk, b), 64'(tx_eop), 64'(e));
      checkOutput($sformatf("p%0d_b%0d_tx_error", pk, b), 64'(tx_error), 64'(b == sopBeat));
      checkOutput($sformatf("p%0d_b%0d_tx_empty", pk, b), 64'(tx_empty), e ? 64'd5 : 64'd0);
    end
    applyStimulus(r, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
  endtask

  // Stall scenario tables for the req1 5-beat packet.
  bit [6:0] stallReady;
  int       stallPres [7];
  int       stallTx   [7];

  initial begin
    stallReady = 7'b1110011;   // bit c is tx_ready in cycle c: 1,1,0,0,1,1,1
    stallPres  = '{0, 1, 2, 2, 2, 3, 4};
    stallTx    = '{0, 1, 1, 1, 2, 3, 4};

    resetMac  = 1'b1;
    req_valid = '0;
    req_sop   = '0;
    req_eop   = '0;
    req_error = '0;
    req_data  = '0;
    req_empty = '0;
    tx_ready  = 1'b1;
    err_clear = 1'b0;
    tick();
    tick();
    resetMac = 1'b0;
    #1;
    checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_pkt_done", 64'(pkt_done), 64'd0);
    checkOutput("rst_err_orphan", 64'(err_orphan), 64'd0);
    checkOutput("rst_err_sop", 64'(err_sop), 64'd0);

    // 1: single 4-beat packet from req0
    $display("[TB] test 1: req0 4-beat packet");
    sendPacket(0, 4, 1, -1);
    tick();
    checkOutput("t1_drain_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);

    // 2: both requesters hold SOP for three packets each, from a fresh pointer
    $display("[TB] test 2: alternating packets");
    resetMac = 1'b1;
    tick();
    resetMac = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p < 5) applyStimulus(1 - (p % 2), 1'b1, 1'b1, 1'b0, 1'b0, beatData(1 - (p % 2), 0, 0), 3'd7);
      sendPacket(p % 2, 2, 10 + p, -1);
    end

    // 3: req1 5-beat packet with MAC stalls; req0 waits with SOP meanwhile
    $display("[TB] test 3: backpressure");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, beatData(1, 30, 0), 3'd7);
    #1;
    checkOutput("t3_bubble_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("t3_grant", 64'(grant_id), 64'd1);
    checkOutput("t3_first_tx_valid", 64'(tx_valid), 64'd0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, beatData(0, 31, 0), 3'd7);
      applyStimulus(1, 1'b1, stallPres[c] == 0, stallPres[c] == 4, 1'b0,
                    beatData(1, 30, stallPres[c]), (stallPres[c] == 4) ? 3'd5 : 3'd7);
      tx_ready = stallReady[c];
      #1;
      checkOutput($sformatf("t3_c%0d_req_ready", c), 64'(req_ready),
                  stallReady[c] ? 64'd2 : 64'd0);
      checkOutput($sformatf("t3_c%0d_pkt_done", c), 64'(pkt_done), 64'(c == 6));
      tick();
      checkOutput($sformatf("t3_c%0d_tx_valid", c), 64'(tx_valid), 64'd1);
      checkOutput($sformatf("t3_c%0d_tx_data", c), tx_data, beatData(1, 30, stallTx[c]));
      checkOutput($sformatf("t3_c%0d_tx_eop", c), 64'(tx_eop), 64'(stallTx[c] == 4));
      checkOutput($sformatf("t3_c%0d_grant", c), 64'(grant_id), 64'd1);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
    tx_ready = 1'b1;
    tick();

    // 4: orphan beat while idle, set-wins-over-clear, then clear
    $display("[TB] test 4: orphan beat");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, beatData(0, 40, 0), 3'd7);
    #1;
    checkOutput("t4_orphan_ready", 64'(req_ready), 64'd1);
    tick();
    checkOutput("t4_err_orphan", 64'(err_orphan), 64'd1);
    checkOutput("t4_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    err_clear = 1'b1;
    tick();
    checkOutput("t4_set_wins", 64'(err_orphan), 64'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
    tick();
    checkOutput("t4_cleared", 64'(err_orphan), 64'd0);
    err_clear = 1'b0;

    // 5: stray SOP on beat 3 of a req0 5-beat packet
    $display("[TB] test 5: SOP inside packet");
    sendPacket(0, 5, 50, 2);
    checkOutput("t5_err_sop", 64'(err_sop), 64'd1);
    checkOutput("t5_err_orphan", 64'(err_orphan), 64'd0);

    // 6: reset on beat 2 of a req1 packet; pointer would otherwise favour req1
    $display("[TB] test 6: reset mid-packet");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, beatData(1, 60, 0), 3'd7);
    tick();
    checkOutput("t6_grant", 64'(grant_id), 64'd1);
    #1;
    checkOutput("t6_b0_ready", 64'(req_ready), 64'd2);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, beatData(1, 60, 1), 3'd7);
    resetMac = 1'b1;
    #1;
    checkOutput("t6_rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    resetMac = 1'b0;
    checkOutput("t6_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("t6_tx_sop", 64'(tx_sop), 64'd0);
    checkOutput("t6_tx_data", tx_data, 64'd0);
    checkOutput("t6_tx_empty", 64'(tx_empty), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_grant_id", 64'(grant_id), 64'd0);
    checkOutput("t6_err_sop", 64'(err_sop), 64'd0);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, beatData(0, 61, 0), 3'd5);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, beatData(1, 62, 0), 3'd7);
    #1;
    checkOutput("t6_arb_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("t6_arb_grant", 64'(grant_id), 64'd0);
    #1;
    checkOutput("t6_single_ready", 64'(req_ready), 64'd1);
    checkOutput("t6_single_pkt_done", 64'(pkt_done), 64'd1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
    checkOutput("t6_single_tx_data", tx_data, beatData(0, 61, 0));
    checkOutput("t6_single_tx_sop", 64'(tx_sop), 64'd1);
    checkOutput("t6_single_tx_eop", 64'(tx_eop), 64'd1);
    checkOutput("t6_single_tx_empty", 64'(tx_empty), 64'd5);
    checkOutput("t6_single_idle", 64'(busy), 64'd0);
    tick();
    checkOutput("t6_next_grant", 64'(grant_id), 64'd1);
    checkOutput("t6_next_busy", 64'(busy), 64'd1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
